// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding and
// the default pattern that the detector bench also expects.
package seq_pattern_pkg;

  localparam int         PAT_W_DEF   = 4;
  localparam int         REP_W_DEF   = 4;
  localparam logic [3:0] PAT_RST_DEF = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_pattern_cnt.sv
// Bit-index / repetition counter pair. bit_idx counts down from PAT_W-1 and
// reloads after bit 0; each reload consumes one repetition.
module seq_pattern_cnt
  import seq_pattern_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_load,
  input  logic [REP_W-1:0]         i_reps,
  input  logic                     i_en,
  output logic [$clog2(PAT_W)-1:0] o_bit_idx,
  output logic                     o_last_bit,
  output logic                     o_last_rep
);

  localparam int               IDX_W   = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  logic [IDX_W-1:0] r_bit_idx;
  logic [REP_W-1:0] r_rep_cnt;

  // Load on an accepted start, step once per transmitted bit.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_idx <= IDX_TOP;
      r_rep_cnt <= '0;
    end else if (i_load) begin
      r_bit_idx <= IDX_TOP;
      r_rep_cnt <= i_reps;
    end else if (i_en) begin
      if (r_bit_idx == '0) begin
        r_bit_idx <= IDX_TOP;
        r_rep_cnt <= r_rep_cnt - 1'b1;
      end else begin
        r_bit_idx <= r_bit_idx - 1'b1;
      end
    end
  end

  assign o_bit_idx  = r_bit_idx;
  assign o_last_bit = (r_bit_idx == '0);
  assign o_last_rep = (r_rep_cnt == REP_W'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends pat_reg MSB-first, reps times back to
// back, with start/busy/done handshake. All outputs are registered and lag
// the state register by one edge, so the first bit appears one cycle after
// the start edge.
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF),
  parameter int               REP_W   = REP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             start,
  input  logic [REP_W-1:0] reps,
  input  logic             pause,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);

  state_t           r_state, w_state_nxt;
  logic [PAT_W-1:0] r_pat;
  logic             r_dout, r_dout_valid, r_busy, r_done;
  logic             w_dout_nxt, w_valid_nxt, w_busy_nxt, w_done_nxt;
  logic             w_cnt_load, w_cnt_en, w_pat_we;
  logic [IDX_W-1:0] w_bit_idx;
  logic             w_last_bit, w_last_rep;

  seq_pattern_cnt #(
    .PAT_W (PAT_W),
    .REP_W (REP_W)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_reps     (reps),
    .i_en       (w_cnt_en),
    .o_bit_idx  (w_bit_idx),
    .o_last_bit (w_last_bit),
    .o_last_rep (w_last_rep)
  );

  // Next state, next registered outputs and counter/pattern controls.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_dout_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_en    = 1'b0;
    w_pat_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pat_we = cfg_we;
        if (start) begin
          if (reps != '0) begin
            w_cnt_load  = 1'b1;
            w_state_nxt = ST_SEND;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      // HOLD resumes straight into emitting the frozen bit, so a pause of
      // n cycles costs exactly n invalid cycles.
      ST_SEND, ST_HOLD: begin
        w_busy_nxt = 1'b1;
        if (pause) begin
          w_dout_nxt  = r_dout;
          w_state_nxt = ST_HOLD;
        end else begin
          w_dout_nxt  = r_pat[w_bit_idx];
          w_valid_nxt = 1'b1;
          w_cnt_en    = 1'b1;
          w_state_nxt = (w_last_bit && w_last_rep) ? ST_DONE : ST_SEND;
        end
      end
      ST_DONE: begin
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Pattern register, writable only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_pat <= PAT_RST;
    else if (w_pat_we) r_pat <= cfg_pattern;
  end

  // Registered (Moore) outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_valid_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter. It emits a programmable PAT_W-bit pattern MSB-first on a one-bit line, repeated a requested number of times. It is the source end of the serial bit-pattern link whose sink is the team's Moore-style pattern detector, and it drives din of that detector in both system use and self-test. Control uses a start/busy/done handshake, and all outputs are registered (Moore).

Parameters:
PAT_W, 4, pattern width in bits (2..16)
PAT_RST, 4'b1011, pattern register value after reset (PAT_W bits)
REP_W, 4, width of the repetition count

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
cfg_we  input  1  load cfg_pattern into the pattern register; honoured only in IDLE
cfg_pattern  input  PAT_W  new pattern value
start  input  1  request transmission; sampled only in IDLE
reps  input  REP_W  number of back-to-back pattern repetitions, captured with start
pause  input  1  freeze transmission while high
dout  output  1  serial data bit (connects to detector din)
dout_valid  output  1  dout carries a pattern bit this cycle
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse at the end of a transfer

Behaviour:
- Reset (async): state=IDLE, pat_reg=PAT_RST, bit_idx=PAT_W-1, rep_cnt=0, dout=0, dout_valid=0, busy=0, done=0.
- States (one-hot or binary; encoding constants live in the package):
  - IDLE: dout=0, dout_valid=0, busy=0.
    - cfg_we=1 loads pat_reg on that edge.
    - start=1 with reps!=0: capture rep_cnt=reps and bit_idx=PAT_W-1, go to SEND.
    - start=1 with reps==0: go to DONE; no bits are sent.
    - start and cfg_we in the same cycle: the new pattern is loaded, and the transfer uses the new pattern.
  - SEND: registered outputs dout=pat_reg[bit_idx], dout_valid=1, busy=1.
    - Each non-paused cycle, bit_idx decrements.
    - At bit_idx==0: if rep_cnt==1, go to DONE; otherwise decrement rep_cnt, set bit_idx=PAT_W-1, and stay in SEND.
    - Repetitions are back-to-back with no gap bit.
  - HOLD: entered from SEND when pause=1. dout holds its last value, dout_valid=0, busy=1, counters frozen. When pause=0, return to SEND and resume at the frozen bit. pause sampled in IDLE or DONE has no effect.
  - DONE: done=1, busy=1, dout=0, dout_valid=0 for exactly one cycle, then IDLE.
- Latency:
  - start sampled at edge N -> first bit (pattern MSB) is visible after edge N+1.
  - Total cycles from start to done with no pause = reps*PAT_W + 1.
- Ignored inputs:
  - start while busy is ignored; no queuing.
  - cfg_we outside IDLE is ignored, so pat_reg is stable during a transfer.
- Arithmetic and widths:
  - bit_idx is $clog2(PAT_W) bits and wraps by reload, never by overflow.
  - rep_cnt is REP_W bits, so the maximum is 2^REP_W-1 repetitions.
- Reset mid-transfer: outputs return to their reset values immediately (async) and no done pulse is produced. pat_reg returns to PAT_RST.
- done and dout_valid are never high in the same cycle.

Decomposition:
- Package seq_pattern_pkg: state encoding constants (IDLE, SEND, HOLD, DONE) and the default pattern constant 4'b1011 shared with the detector bench.
- The bit/repetition counter pair is natural as one sub-module, seq_pattern_cnt. It provides load, enable, bit_idx, and last_bit/last_rep flags.
- The FSM and output registers stay in the top module.

Test Plan:
1. Reset, then start with reps=1 and the default pattern -> dout_valid high 4 cycles with dout=1,0,1,1. done pulses in cycle 5 after start. busy is high cycles 1..5.
2. cfg_we=1 with cfg_pattern=4'b0110 in IDLE, then start with reps=3 -> 12 valid bits 0110 0110 0110, back-to-back. done appears 13 cycles after start. A downstream 1011 detector never asserts z.
3. Default pattern, reps=2, output fed into the detector -> dout sequence 1011 1011. Detector z is high in the cycle after the 4th bit and again after the 8th bit.
4. reps=1, pause held high for 3 cycles after the second bit -> dout_valid low for 3 cycles, dout frozen at 0. Transmission resumes with 1,1. done appears 8 cycles after start.
5. start with reps=0 -> no dout_valid, done pulses one cycle later. start re-asserted during busy in the reps=2 case has no effect on the bit count (8 bits).
6. Assert reset during bit 3 of a reps=2 transfer -> all outputs are 0 immediately and no done pulse. After release, pat_reg=1011 and a fresh start with reps=1 works normally.
